mem_request_initiator: RTL

- Initiator side of the data-memory load/store handshake. Takes one execute-stage request at a time and drives memRead, memWrite, result and rd2, then strobes executeComplete.
- Waits for memoryOperationComplete, clears the responder with a resetDataMemory pulse, then returns rdata to writeback.
- Sits between the execute stage and the data memory. Replaces the ad-hoc strobe logic in the execute stage.

---
 rtl/mem_request_initiator_pkg.sv | 35 +++
 rtl/mem_request_initiator_timeout_counter.sv | 25 ++
 rtl/mem_request_initiator.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mem_request_initiator_pkg.sv
// Shared encodings for the data-memory request initiator.
// Holds FSM state codes, op codes and the request decoder.
package mem_request_initiator_pkg;

  localparam int unsigned DEFAULT_DATA_W = 16;
  localparam int unsigned CNT_W          = 16;
  localparam int unsigned STATE_W        = 3;
  localparam int unsigned OP_W           = 2;

  typedef logic [STATE_W-1:0] state_t;
  typedef logic [OP_W-1:0]    op_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t SETUP  = 3'd1;
  localparam state_t STROBE = 3'd2;
  localparam state_t CLEAR  = 3'd3;
  localparam state_t DRAIN  = 3'd4;
  localparam state_t RESP   = 3'd5;

  localparam op_t OP_NONE    = 2'd0;
  localparam op_t OP_LOAD    = 2'd1;
  localparam op_t OP_STORE   = 2'd2;
  localparam op_t OP_ILLEGAL = 2'd3;

  // Both strobes high is not a valid memory operation.
  function automatic op_t decode_op(input logic rd, input logic wr);
    op_t op;
    if (rd && wr)  op = OP_ILLEGAL;
    else if (wr)   op = OP_STORE;
    else if (rd)   op = OP_LOAD;
    else           op = OP_NONE;
    return op;
  endfunction

endpackage

// File: rtl/mem_request_initiator_timeout_counter.sv
// Cycle counter bounding the wait in STROBE and DRAIN.
// expire_c flags the cycle whose increment reaches LIMIT.
module mem_timeout_counter
  import mem_request_initiator_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic resetN,
  input  logic clear,
  input  logic enable,
  output logic expire_c
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)      count <= '0;
    else if (clear)   count <= '0;
    else if (enable)  count <= count + CNT_W'(1);
  end

  assign expire_c = enable && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_request_initiator.sv
// Initiator side of the data-memory load/store handshake.
// One request at a time: setup, strobe, clear the responder, respond.
module mem_request_initiator
  import mem_request_initiator_pkg::*;
#(
  parameter int unsigned DATA_W         = DEFAULT_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              exValid,
  input  logic              exMemRead,
  input  logic              exMemWrite,
  input  logic [DATA_W-1:0] exResult,
  input  logic [DATA_W-1:0] exRd2,
  output logic              exReady,
  output logic              memRead,
  output logic              memWrite,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] rd2,
  output logic              executeComplete,
  output logic              resetDataMemory,
  input  logic              memoryOperationComplete,
  input  logic [DATA_W-1:0] rdata,
  output logic              wbValid,
  input  logic              wbReady,
  output logic [DATA_W-1:0] wbData,
  output logic              wbIsStore,
  output logic              wbError
);

  state_t state_q, state_d;
  op_t    op_q, op_d, req_op;
  logic   seen_low_q, seen_low_d;
  logic   accept, mem_done, expire, cnt_enable, cnt_clear;

  logic              mem_read_d, mem_write_d, exec_d, clear_d, wb_valid_d;
  logic              wb_is_store_d, wb_error_d;
  logic [DATA_W-1:0] result_d, rd2_d, wb_data_d;

  assign exReady = (state_q == IDLE);
  assign accept  = exValid && exReady;
  assign req_op  = decode_op(exMemRead, exMemWrite);
  // A complete flag left stale by a reset only counts once it has dropped.
  assign mem_done = memoryOperationComplete && seen_low_q;

  assign cnt_enable = (state_q == STROBE) || (state_q == DRAIN);
  assign cnt_clear  = !((state_d == STROBE) || (state_d == DRAIN));

  mem_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk      (clk),
    .resetN   (resetN),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .expire_c (expire)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (req_op == OP_ILLEGAL) ? RESP : SETUP;
      SETUP:   state_d = STROBE;
      STROBE:  if (mem_done || expire) state_d = CLEAR;
      CLEAR:   state_d = memoryOperationComplete ? DRAIN : RESP;
      DRAIN:   if (!memoryOperationComplete || expire) state_d = RESP;
      RESP:    if (wbReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, decoded from the next state.
  always_comb begin
    op_d          = op_q;
    seen_low_d    = seen_low_q;
    result_d      = result;
    rd2_d         = rd2;
    wb_data_d     = wbData;
    wb_is_store_d = wbIsStore;
    wb_error_d    = wbError;
    if (accept) begin
      op_d          = req_op;
      seen_low_d    = 1'b0;
      result_d      = exResult;
      rd2_d         = exRd2;
      wb_data_d     = '0;
      wb_is_store_d = (req_op == OP_STORE);
      wb_error_d    = (req_op == OP_ILLEGAL);
    end
    if (((state_q == SETUP) || (state_q == STROBE)) && !memoryOperationComplete)
      seen_low_d = 1'b1;
    if (state_q == STROBE) begin
      if (mem_done) begin
        if ((op_q == OP_LOAD) || (op_q == OP_NONE)) wb_data_d = rdata;
      end else if (expire) begin
        wb_error_d = 1'b1;
      end
    end
    if ((state_q == DRAIN) && memoryOperationComplete && expire) begin
      wb_error_d = 1'b1;
      wb_data_d  = '0;
    end
    mem_read_d  = (state_d != IDLE) && (op_d == OP_LOAD);
    mem_write_d = (state_d != IDLE) && (op_d == OP_STORE);
    exec_d      = (state_d == STROBE);
    clear_d     = (state_d == CLEAR);
    wb_valid_d  = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      op_q            <= OP_NONE;
      seen_low_q      <= 1'b0;
      memRead         <= 1'b0;
      memWrite        <= 1'b0;
      result          <= '0;
      rd2             <= '0;
      executeComplete <= 1'b0;
      resetDataMemory <= 1'b0;
      wbValid         <= 1'b0;
      wbData          <= '0;
      wbIsStore       <= 1'b0;
      wbError         <= 1'b0;
    end else begin
      op_q            <= op_d;
      seen_low_q      <= seen_low_d;
      memRead         <= mem_read_d;
      memWrite        <= mem_write_d;
      result          <= result_d;
      rd2             <= rd2_d;
      executeComplete <= exec_d;
      resetDataMemory <= clear_d;
      wbValid         <= wb_valid_d;
      wbData          <= wb_data_d;
      wbIsStore       <= wb_is_store_d;
      wbError         <= wb_error_d;
    end
  end

endmodule
